// File: rtl/frame_bank_ctrl.sv
// frame_bank_ctrl: double-buffer scheduler between the UART pixel stream and
// the LED scan driver. Incoming frames fill the back bank (~rd_bank) while the
// driver scans the front bank. The banks swap only when a complete frame is
// waiting and the driver reports a frame boundary.
// Optional feature: define FILL_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES idle cycles in FILL.
module frame_bank_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int FRAME_PIXELS   = 256,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic                  wr_sof,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  scan_frame_end,
  output logic                  rd_bank,
  output logic                  swap_pulse,
  output logic [1:0]            state,
  output logic [7:0]            err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_READY = 2'b10,
    S_SWAP  = 2'b11
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_PIXELS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_wcnt;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    r_rd_bank;
  logic                    r_mem_we;
  logic [ADDR_WIDTH:0]     r_mem_waddr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [7:0]              r_err_cnt;
  logic                    w_xfer;
  logic                    w_we;
  logic                    w_resync;
  logic                    w_last;
  logic                    w_timeout;

  assign w_xfer = wr_valid & wr_ready;

  // Decide whether this cycle writes a pixel and at which index.
  always_comb begin
    w_we     = 1'b0;
    w_resync = 1'b0;
    w_idx    = r_wcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer && wr_sof) begin
          w_we  = 1'b1;
          w_idx = '0;
        end
      end
      S_FILL: begin
        if (w_xfer) begin
          w_we = 1'b1;
          if (wr_sof) begin
            w_idx    = '0;
            w_resync = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_last = w_we && (w_idx == LAST_IDX);

`ifdef FILL_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] r_idle_cnt;

  // Count consecutive FILL cycles without a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idle_cnt <= '0;
    else if (r_state != S_FILL || w_xfer)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + IW'(1);
  end

  // Fires on the TIMEOUT_CYCLES-th idle cycle, so the frame is dropped at its end.
  assign w_timeout = (r_state == S_FILL) && !w_xfer &&
                     (r_idle_cnt == IW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_we) w_next = w_last ? S_READY : S_FILL;
      S_FILL: begin
        if (w_last)
          w_next = S_READY;
        else if (w_timeout)
          w_next = S_IDLE;
      end
      S_READY: if (scan_frame_end) w_next = S_SWAP;
      S_SWAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    wr_ready   = (r_state == S_IDLE) || (r_state == S_FILL);
    swap_pulse = (r_state == S_SWAP);
  end

  // Pixel counter: next free index of the back bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wcnt <= '0;
    else if (w_timeout)
      r_wcnt <= '0;
    else if (w_we)
      r_wcnt <= w_last ? '0 : w_idx + ADDR_WIDTH'(1);
  end

  // Front bank toggles on entry to SWAP so rd_bank and swap_pulse change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rd_bank <= 1'b0;
    else if (r_state == S_READY && scan_frame_end)
      r_rd_bank <= ~r_rd_bank;
  end

  // Registered memory write port; address and data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_we;
      if (w_we) begin
        r_mem_waddr <= {~r_rd_bank, w_idx};
        r_mem_wdata <= wr_data;
      end
    end
  end

  // Saturating error counter for resyncs and timeouts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if ((w_resync || w_timeout) && r_err_cnt != '1)
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign rd_bank   = r_rd_bank;
  assign mem_we    = r_mem_we;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign err_cnt   = r_err_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Testbench for frame_bank_ctrl with FRAME_PIXELS=16, TIMEOUT_CYCLES=50.
// A frame-level reference model predicts each cycle's outputs; a shadow copy
// of the frame memory confirms every swap exposes the last complete frame.
module tb_frame_bank_ctrl;
  localparam int AW = 8;
  localparam int FP = 16;
  localparam int DW = 24;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_sof = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          scan_frame_end = 1'b0;
  logic          wr_ready;
  logic          mem_we;
  logic [AW:0]   mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          rd_bank;
  logic          swap_pulse;
  logic [1:0]    state;
  logic [7:0]    err_cnt;

  frame_bank_ctrl #(
    .ADDR_WIDTH(AW),
    .FRAME_PIXELS(FP),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_sof(wr_sof),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .mem_we(mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .scan_frame_end(scan_frame_end),
    .rd_bank(rd_bank),
    .swap_pulse(swap_pulse),
    .state(state),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 filling, 2 frame complete, 3 swapping.
  int m_st, m_front, m_cnt, m_err, m_idle;
  bit m_we;
  int m_addr, m_data;
  int m_frame[FP];
  int m_last[FP];
  int tb_mem[2*(1<<AW)];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_front = 0; m_cnt = 0; m_err = 0; m_idle = 0;
    m_we = 1'b0; m_addr = 0; m_data = 0;
  endfunction

  function automatic void model_update(input bit v, input bit sof, input int d, input bit sfe);
    int  st0 = m_st;
    bit  xfer = v && (st0 == 0 || st0 == 1);
    bit  wr = 1'b0;
    int  idx = 0;
    m_we = 1'b0;
    if (st0 == 0 && xfer && sof) begin
      wr = 1'b1;
    end else if (st0 == 1 && xfer) begin
      wr = 1'b1;
      if (sof) begin
        if (m_err < 255) m_err++;
      end else begin
        idx = m_cnt;
      end
    end else if (st0 == 2 && sfe) begin
      m_st = 3;
      m_front = 1 - m_front;
    end else if (st0 == 3) begin
      m_st = 0;
    end
    if (wr) begin
      m_we = 1'b1;
      m_addr = (1 - m_front) * (1 << AW) + idx;
      m_data = d;
      m_frame[idx] = d;
      if (idx == FP - 1) begin
        m_st = 2;
        m_cnt = 0;
        m_last = m_frame;
      end else begin
        m_st = 1;
        m_cnt = idx + 1;
      end
    end
    if (st0 == 1 && !xfer) begin
      m_idle++;
`ifdef FILL_TIMEOUT_EN
      if (m_idle == TO) begin
        m_st = 0;
        m_cnt = 0;
        m_idle = 0;
        if (m_err < 255) m_err++;
      end
`endif
    end else begin
      m_idle = 0;
    end
  endfunction

  task automatic check_outputs();
    int bad;
    if (mem_we === 1'b1) tb_mem[mem_waddr] = int'(mem_wdata);
    check("state", 32'(state), m_st);
    check("rd_bank", 32'(rd_bank), m_front);
    check("wr_ready", 32'(wr_ready), 32'(m_st < 2));
    check("swap_pulse", 32'(swap_pulse), 32'(m_st == 3));
    check("err_cnt", 32'(err_cnt), m_err);
    check("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we) begin
      check("mem_waddr", 32'(mem_waddr), m_addr);
      check("mem_wdata", 32'(mem_wdata), m_data);
    end
    if (m_st == 3) begin
      bad = 0;
      for (int i = 0; i < FP; i++)
        if (tb_mem[m_front * (1 << AW) + i] != m_last[i]) bad++;
      check("swap_frame_content", bad, 0);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_state", 32'(state), 0);
    check("rst_rd_bank", 32'(rd_bank), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_waddr", 32'(mem_waddr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_swap_pulse", 32'(swap_pulse), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
  endtask

  // Inputs are applied just after a rising edge, outputs checked at the falling edge.
  task automatic step(input bit v, input bit sof, input logic [DW-1:0] d, input bit sfe);
    wr_valid = v;
    wr_sof = sof;
    wr_data = d;
    scan_frame_end = sfe;
    @(negedge clk);
    check_outputs();
    model_update(v, sof, int'(d), sfe);
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;

    // First frame into bank 1, data = pixel index.
    for (int i = 0; i < FP; i++) step(1'b1, i == 0, DW'(i), 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    check("t1_ready", 32'(state), 2);
    check("t1_wr_ready", 32'(wr_ready), 0);

    // Swap, then second frame into bank 0.
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < FP; i++) step(1'b1, i == 0, DW'($urandom), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);

    // Resync after 5 pixels; last pixel coincides with scan_frame_end.
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, DW'($urandom), 1'b0);
    step(1'b1, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, DW'($urandom), 1'b0);
    step(1'b1, 1'b0, DW'($urandom), 1'b1);
    repeat (4) step(1'b0, 1'b0, '0, 1'b0);
    check("t4_no_swap", 32'(state), 2);
    check("t3_err", 32'(err_cnt), 1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    // Reset asserted mid-FILL while rd_bank is 1.
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, DW'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Non-sof pixels in IDLE are dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'($urandom), 1'b0);

    // Three pixels then a long idle gap.
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, DW'($urandom), 1'b0);
    repeat (TO + 5) step(1'b0, 1'b0, '0, 1'b0);
`ifdef FILL_TIMEOUT_EN
    check("t5_timeout_state", 32'(state), 0);
    check("t5_timeout_err", 32'(err_cnt), 1);
`else
    check("t5_hold_state", 32'(state), 1);
`endif
    check("t5_rd_bank", 32'(rd_bank), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           DW'($urandom), $urandom_range(0, 7) == 0);

    // Drain any pending swap, then saturate err_cnt with back-to-back resyncs.
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 270; i++) step(1'b1, 1'b1, DW'($urandom), 1'b0);
    check("err_saturated", 32'(err_cnt), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
